// File: rtl/logic_unit_arbiter_pkg.sv
// Shared types for the two-requester logic unit arbiter.
package logic_unit_arbiter_pkg;

    localparam int LOGIC_REQ_NUM = 2;
    localparam int XLEN          = 32;

    // Encodings 6 and 7 are unused; the datapath returns 0 for them.
    typedef enum logic [2:0] {
        logicop_and = 3'd0,
        logicop_or  = 3'd1,
        logicop_xor = 3'd2,
        logicop_sll = 3'd3,
        logicop_srl = 3'd4,
        logicop_sra = 3'd5
    } rv32_logicop;

    typedef struct packed {
        logic [XLEN-1:0] data_a;
        logic [XLEN-1:0] data_b;
        rv32_logicop     logicop;
    } rv32_logic_req;

    // Extracts the 32-bit lane belonging to requester idx from a 64-bit bus.
    function automatic logic [XLEN-1:0] lane_of(input logic [2*XLEN-1:0] bus, input logic idx);
        return idx ? bus[2*XLEN-1:XLEN] : bus[XLEN-1:0];
    endfunction

endpackage

// File: rtl/logic_unit.sv
// Combinational bitwise/shift datapath shared by both requesters.
module logic_unit
    import logic_unit_arbiter_pkg::*;
(
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  rv32_logicop     i_op,
    output logic [XLEN-1:0] o_result
);

    logic [4:0] shamt;
    assign shamt = i_b[4:0];

    // Operation select; unknown encodings yield zero.
    always_comb begin
        o_result = '0;
        case (i_op)
            logicop_and: o_result = i_a & i_b;
            logicop_or:  o_result = i_a | i_b;
            logicop_xor: o_result = i_a ^ i_b;
            logicop_sll: o_result = i_a << shamt;
            logicop_srl: o_result = i_a >> shamt;
            logicop_sra: o_result = $unsigned($signed(i_a) >>> shamt);
            default:     o_result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter; the pointer names the preferred requester on contention.
module rr_arbiter2
    import logic_unit_arbiter_pkg::*;
(
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [LOGIC_REQ_NUM-1:0] i_req,
    input  logic                     i_accept,
    output logic [LOGIC_REQ_NUM-1:0] o_grant
);

    logic ptr_q;
    logic ptr_d;

    // One-hot grant and pointer advance: after serving n, prefer the other requester.
    always_comb begin
        o_grant = '0;
        ptr_d   = ptr_q;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = ptr_q ? 2'b10 : 2'b01;
            default: o_grant = 2'b00;
        endcase
        if (i_accept) begin
            ptr_d = o_grant[0];
        end
    end

    // Pointer register with synchronous reset to requester 0.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Shares one logic_unit between two valid/ready requesters, with a one-entry response register.
module logic_unit_arbiter
    import logic_unit_arbiter_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic [LOGIC_REQ_NUM-1:0]            i_req_valid,
    output logic [LOGIC_REQ_NUM-1:0]            o_req_ready,
    input  logic [LOGIC_REQ_NUM*XLEN-1:0]       i_req_data_a,
    input  logic [LOGIC_REQ_NUM*XLEN-1:0]       i_req_data_b,
    input  rv32_logicop [LOGIC_REQ_NUM-1:0]     i_req_logicop,
    input  logic [LOGIC_REQ_NUM-1:0][TAG_W-1:0] i_req_tag,
    output logic                                o_rsp_valid,
    input  logic                                i_rsp_ready,
    output logic [XLEN-1:0]                     o_rsp_data,
    output logic [TAG_W-1:0]                    o_rsp_tag,
    output logic                                o_rsp_src
);

    logic [LOGIC_REQ_NUM-1:0] grant;
    logic                     can_accept;
    logic                     accept;
    logic                     sel;
    rv32_logic_req            req_sel;
    logic [XLEN-1:0]          result;

    logic                     rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]          rsp_data_q,  rsp_data_d;
    logic [TAG_W-1:0]         rsp_tag_q,   rsp_tag_d;
    logic                     rsp_src_q,   rsp_src_d;

    rr_arbiter2 u_arb (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_req    (i_req_valid),
        .i_accept (accept),
        .o_grant  (grant)
    );

    logic_unit u_lu (
        .i_a      (req_sel.data_a),
        .i_b      (req_sel.data_b),
        .i_op     (req_sel.logicop),
        .o_result (result)
    );

    // Handshake: a slot is free when empty or being drained this cycle; nothing is accepted in reset.
    always_comb begin
        can_accept  = !rsp_valid_q || i_rsp_ready;
        o_req_ready = (i_rst_n && can_accept) ? grant : '0;
        accept      = |(o_req_ready & i_req_valid);
        sel         = grant[1];
    end

    // Route the granted lane's operands into the shared datapath.
    always_comb begin
        req_sel.data_a  = lane_of(i_req_data_a, sel);
        req_sel.data_b  = lane_of(i_req_data_b, sel);
        req_sel.logicop = i_req_logicop[sel];
    end

    // Response register next-state: load on accept, clear valid on drain, otherwise hold.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_src_d   = rsp_src_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = result;
            rsp_tag_d   = i_req_tag[sel];
            rsp_src_d   = sel;
        end else if (i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Response register with synchronous reset; a pending response is dropped on reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_src_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_src_q   <= rsp_src_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_rsp_tag   = rsp_tag_q;
    assign o_rsp_src   = rsp_src_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: a reference model predicts grants and responses.
module tb_logic_unit_arbiter;
    import logic_unit_arbiter_pkg::*;

    localparam int TAG_W = 4;

    logic                  clk;
    logic                  rst_n;
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [63:0]           req_a;
    logic [63:0]           req_b;
    rv32_logicop [1:0]     req_op;
    logic [1:0][TAG_W-1:0] req_tag;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [TAG_W-1:0]      rsp_tag;
    logic                  rsp_src;

    int n_vec = 0;
    int n_err = 0;

    logic [36:0] sb_q[$];
    logic        mdl_valid = 1'b0;
    logic        mdl_ptr   = 1'b0;
    logic [1:0]  exp_ready;
    logic [1:0]  exp_grant;
    logic        sel;
    logic [36:0] exp_rsp;

    logic_unit_arbiter #(.TAG_W(TAG_W)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_data_a  (req_a),
        .i_req_data_b  (req_b),
        .i_req_logicop (req_op),
        .i_req_tag     (req_tag),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_data    (rsp_data),
        .o_rsp_tag     (rsp_tag),
        .o_rsp_src     (rsp_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_op(input logic [31:0] a, input logic [31:0] b, input rv32_logicop op);
        logic [4:0] s;
        s = b[4:0];
        case (op)
            logicop_and: return a & b;
            logicop_or:  return a | b;
            logicop_xor: return a ^ b;
            logicop_sll: return a << s;
            logicop_srl: return a >> s;
            logicop_sra: return $unsigned($signed(a) >>> s);
            default:     return 32'h0;
        endcase
    endfunction

    // Reference model and checker, evaluated mid-cycle while inputs are stable.
    always @(negedge clk) begin
        case (req_valid)
            2'b01:   exp_grant = 2'b01;
            2'b10:   exp_grant = 2'b10;
            2'b11:   exp_grant = mdl_ptr ? 2'b10 : 2'b01;
            default: exp_grant = 2'b00;
        endcase
        exp_ready = (rst_n && (!mdl_valid || rsp_ready)) ? exp_grant : 2'b00;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(mdl_valid));
        if (mdl_valid && sb_q.size() > 0) begin
            chk("rsp_data", 64'(rsp_data), 64'(sb_q[0][31:0]));
            chk("rsp_tag",  64'(rsp_tag),  64'(sb_q[0][35:32]));
            chk("rsp_src",  64'(rsp_src),  64'(sb_q[0][36]));
        end
        if (!rst_n) begin
            mdl_valid = 1'b0;
            mdl_ptr   = 1'b0;
            sb_q.delete();
        end else begin
            if (mdl_valid && rsp_ready && sb_q.size() > 0) void'(sb_q.pop_front());
            if (exp_ready != 2'b00) begin
                sel     = exp_ready[1];
                exp_rsp = {sel, req_tag[sel],
                           ref_op(sel ? req_a[63:32] : req_a[31:0],
                                  sel ? req_b[63:32] : req_b[31:0], req_op[sel])};
                sb_q.push_back(exp_rsp);
                mdl_valid = 1'b1;
                mdl_ptr   = ~sel;
            end else if (rsp_ready) begin
                mdl_valid = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int n, input logic [31:0] a, input logic [31:0] b,
                            input rv32_logicop op, input logic [TAG_W-1:0] tag);
        req_a[n*32 +: 32] = a;
        req_b[n*32 +: 32] = b;
        req_op[n]         = op;
        req_tag[n]        = tag;
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        req_op    = {logicop_and, logicop_and};
        set_lane(0, 32'hFF00FF00, 32'h0F0F0F0F, logicop_and, 4'h1);
        set_lane(1, 32'h00000001, 32'h00000025, logicop_sll, 4'h2);

        // Reset held with both requesters valid.
        repeat (3) step();
        rst_n = 1'b1;

        // Contention: expect grants 0,1,0,1.
        @(negedge clk);
        chk("first_grant", 64'(req_ready), 64'h1);
        repeat (4) step();
        req_valid = 2'b00;
        step();

        // Single sra request.
        set_lane(0, 32'h80000000, 32'h00000004, logicop_sra, 4'h3);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        @(negedge clk);
        chk("sra_data", 64'(rsp_data), 64'hF8000000);
        chk("sra_tag",  64'(rsp_tag),  64'h3);
        step();

        // Backpressure with both requesters pending.
        set_lane(0, 32'hFF00FF00, 32'h0F0F0F0F, logicop_and, 4'h4);
        set_lane(1, 32'h00000001, 32'h00000025, logicop_sll, 4'h5);
        req_valid = 2'b01;
        step();
        rsp_ready = 1'b0;
        req_valid = 2'b11;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready", 64'(req_ready), 64'h0);
            chk("bp_data",  64'(rsp_data),  64'h0F000F00);
            step();
        end
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_reload_valid", 64'(rsp_valid), 64'h1);
        chk("bp_reload_data",  64'(rsp_data),  64'h00000020);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();

        // Back-to-back xor from requester 1.
        set_lane(1, 32'hAAAAAAAA, 32'hFFFFFFFF, logicop_xor, 4'h9);
        req_valid = 2'b10;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_valid", 64'(rsp_valid), 64'h1);
                chk("b2b_data",  64'(rsp_data),  64'h55555555);
            end
            step();
        end
        req_valid = 2'b00;
        step();

        // Unknown encoding and an or/srl mix.
        set_lane(0, 32'h12345678, 32'h0000FFFF, rv32_logicop'(3'd7), 4'hA);
        set_lane(1, 32'hF0000000, 32'h00000024, logicop_srl, 4'hB);
        req_valid = 2'b11;
        repeat (2) step();
        set_lane(0, 32'h12340000, 32'h00005678, logicop_or, 4'hC);
        req_valid = 2'b01;
        step();
        req_valid = 2'b00;
        step();

        // Mid-operation reset with pointer at 1 and a pending response.
        set_lane(0, 32'h0000FFFF, 32'h00FF00FF, logicop_and, 4'hD);
        req_valid = 2'b01;
        rsp_ready = 1'b0;
        step();
        req_valid = 2'b00;
        rst_n     = 1'b0;
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        @(negedge clk);
        chk("post_rst_valid", 64'(rsp_valid), 64'h0);
        chk("post_rst_grant", 64'(req_ready), 64'h1);
        repeat (3) step();
        req_valid = 2'b00;
        repeat (2) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
